// File: rtl/rot_unit_arb.sv
// Two-requester round-robin front end for the shared 16-bit rotate-right network.
// It derives ROR/SLL/SRL/SRA with thermometer fill masks and holds each result under valid/ready.
module rot_unit_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data0,
  input  logic [15:0] req_data1,
  input  logic [3:0]  req_amt0,
  input  logic [3:0]  req_amt1,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            accept;
  logic            grant_id;
  logic [DW-1:0]   op_data;
  logic [AW-1:0]   op_amt;
  logic [1:0]      op_op;
  logic            op_id;

  logic [AW-1:0]   rot_amt;
  logic [DW-1:0]   s1, s2, s3, rot;
  logic [DW-1:0]   lo_mask, hi_mask;
  logic [DW-1:0]   result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, arbitration and combinational grant
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    grant_id  = 1'b0;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          grant_id  = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Grant must not leak out while the block is held in reset.
    if (!rst_n) req_ready = 2'b00;
  end

  // Operand capture, round-robin history and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_data    <= '0;
      op_amt     <= '0;
      op_op      <= OP_ROR;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        op_id      <= grant_id;
        op_data    <= grant_id ? req_data1 : req_data0;
        op_amt     <= grant_id ? req_amt1  : req_amt0;
        op_op      <= grant_id ? req_op1   : req_op0;
      end
      if (state == EXEC) begin
        rsp_data  <= result;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == DONE && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Left shifts reuse the rotate-right network with amount (16 - a) mod 16.
  always_comb begin
    rot_amt = (op_op == OP_SLL) ? AW'(4'd0 - op_amt) : op_amt;
    s1  = rot_amt[0] ? {op_data[0],   op_data[DW-1:1]} : op_data;
    s2  = rot_amt[1] ? {s1[1:0],      s1[DW-1:2]}      : s1;
    s3  = rot_amt[2] ? {s2[3:0],      s2[DW-1:4]}      : s2;
    rot = rot_amt[3] ? {s3[7:0],      s3[DW-1:8]}      : s3;
  end

  // Thermometer masks: lo_mask covers bits [a-1:0], hi_mask covers [15:16-a].
  always_comb begin
    lo_mask = '0;
    hi_mask = '0;
    for (int i = 0; i < DW; i++) begin
      lo_mask[i] = (AW'(i) < op_amt);
    end
    for (int i = 0; i < DW; i++) begin
      hi_mask[i] = lo_mask[DW-1-i];
    end
  end

  // Fill selection per op
  always_comb begin
    result = rot;
    case (op_op)
      OP_ROR:  result = rot;
      OP_SLL:  result = rot & ~lo_mask;
      OP_SRL:  result = rot & ~hi_mask;
      OP_SRA:  result = (rot & ~hi_mask) | (hi_mask & {DW{op_data[DW-1]}});
      default: result = rot;
    endcase
  end

endmodule

// File: tb/tb_rot_unit_arb.sv
// Directed self-checking bench for rot_unit_arb: ops, boundaries, fairness, backpressure, reset.
module tb_rot_unit_arb;

  localparam logic [1:0] ROR = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] SRL = 2'b10;
  localparam logic [1:0] SRA = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data0, req_data1;
  logic [3:0]  req_amt0, req_amt1;
  logic [1:0]  req_op0, req_op1;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;

  int checks;
  int errors;

  rot_unit_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_amt0  (req_amt0),
    .req_amt1  (req_amt1),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issue one request, return what the DUT showed (grant, result, latency).
  task automatic run_one(input logic id, input logic [15:0] d, input logic [3:0] a,
                         input logic [1:0] op, output logic [1:0] rdy,
                         output logic [15:0] dout, output logic idout, output int lat);
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin
      req_data1 = d;  req_amt1 = a;  req_op1 = op;
      req_data0 = ~d; req_amt0 = ~a; req_op0 = ~op;
      req_valid = 2'b10;
    end else begin
      req_data0 = d;  req_amt0 = a;  req_op0 = op;
      req_data1 = ~d; req_amt1 = ~a; req_op1 = ~op;
      req_valid = 2'b01;
    end
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = 2'b00;
    req_data0 = 16'h5A5A; req_data1 = 16'hA5A5;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    dout  = rsp_data;
    idout = rsp_id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_data0 = 16'h1234; req_data1 = 16'h4321;
    req_amt0 = 4'd3; req_amt1 = 4'd5; req_op0 = ROR; req_op1 = SRL;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first();
    logic [1:0] rdy; logic [15:0] d; logic id; int lat;
    run_one(1'b0, 16'h8001, 4'd1, ROR, rdy, d, id, lat);
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL first_req_ready got %b want 01", rdy); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL first_latency got %0d want 2", lat); end
    checks++; if (d !== 16'hC000) begin errors++; $display("FAIL first_rsp_data got %h want c000", d); end
    checks++; if (id !== 1'b0) begin errors++; $display("FAIL first_rsp_id got %b want 0", id); end
  endtask

  task automatic test_ops();
    logic [15:0] vd [12] = '{16'h8F0F, 16'h8F0F, 16'h8F0F, 16'h8F0F, 16'h8F0F, 16'h8F0F,
                             16'h8F0F, 16'h8F0F, 16'h0001, 16'h8000, 16'h8000, 16'h4000};
    logic [3:0]  va [12] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0,
                             4'd15, 4'd15, 4'd15, 4'd15};
    logic [1:0]  vo [12] = '{SLL, SRL, SRA, ROR, ROR, SLL, SRL, SRA, SLL, SRA, SRL, SRA};
    logic [15:0] ve [12] = '{16'hF0F0, 16'h08F0, 16'hF8F0, 16'hF8F0, 16'h8F0F, 16'h8F0F,
                             16'h8F0F, 16'h8F0F, 16'h8000, 16'hFFFF, 16'h0001, 16'h0000};
    logic [1:0] rdy; logic [15:0] d; logic id; int lat;
    for (int i = 0; i < 12; i++) begin
      run_one(1'(i % 2), vd[i], va[i], vo[i], rdy, d, id, lat);
      checks++;
      if (d !== ve[i] || id !== 1'(i % 2) || lat !== 2)
        begin errors++; $display("FAIL op_vec%0d got data %h id %b lat %0d want %h %b 2", i, d, id, lat, ve[i], 1'(i % 2)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_data0 = 16'h1111; req_amt0 = 4'd0; req_op0 = ROR;
    req_data1 = 16'h2222; req_amt1 = 4'd0; req_op1 = SRA;
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_rdy = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready cyc%0d got %b want %b", i, req_ready, exp_rdy); end
      checks++;
      if (rsp_valid !== (i % 3 == 2)) begin errors++; $display("FAIL b2b_valid cyc%0d got %b want %b", i, rsp_valid, (i % 3 == 2)); end
      if (i % 3 == 2) begin
        checks++;
        if (rsp_id !== 1'((i / 3) % 2) || rsp_data !== (((i / 3) % 2 == 0) ? 16'h1111 : 16'h2222))
          begin errors++; $display("FAIL b2b_rsp cyc%0d got id %b data %h want id %b", i, rsp_id, rsp_data, 1'((i / 3) % 2)); end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_data0 = 16'h00F0; req_amt0 = 4'd4; req_op0 = SRL;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got %b want 01", req_ready); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h000F || req_ready !== 2'b00)
        begin errors++; $display("FAIL bp_hold cyc%0d got v %b data %h rdy %b want 1 000f 00", i, rsp_valid, rsp_data, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_release got v %b rdy %b want 1 00", rsp_valid, req_ready); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_grant got v %b rdy %b want 0 01", rsp_valid, req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_data0 = 16'hABCD; req_amt0 = 4'd4; req_op0 = ROR;
    req_data1 = 16'h0F00; req_amt1 = 4'd8; req_op1 = ROR;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 16'h0000 || req_ready !== 2'b00)
      begin errors++; $display("FAIL midreset_clear got v %b id %b data %h rdy %b want 0 0 0000 00", rsp_valid, rsp_id, rsp_data, req_ready); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_rsp got %0d want 0", seen); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL midreset_grant1 got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h000F)
      begin errors++; $display("FAIL midreset_rsp got v %b id %b data %h want 1 1 000f", rsp_valid, rsp_id, rsp_data); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
